dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Sequences all 32-bit data-memory accesses onto a byte-wide (8-bit) data memory, one byte per cycle, big-endian.
- Arbitrates that single memory port between two requesters:
  - the processor load/store/stack path (cpu);
  - an auxiliary master (aux: loader/debug/DMA).
- Gives the processor a stall indication while its access is outstanding.

Parameters:
- ADDR_W, 5, byte-address width; memory depth is 2**ADDR_W bytes (32 bytes by default).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  cpu access request; held high until cpu_done.
- cpu_we  in  1  1 = write word, 0 = read word; stable while cpu_req is high.
- cpu_addr  in  ADDR_W  byte address of the word's MSB; stable while cpu_req is high.
- cpu_wdata  in  32  write word; stable while cpu_req is high.
- cpu_gnt  out  1  high while cpu owns the port.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  read word, valid when cpu_done is high.
- cpu_stall  out  1  cpu_req & ~cpu_done (combinational).
- aux_req, aux_we, aux_addr, aux_wdata, aux_gnt, aux_done, aux_rdata: same widths and semantics as the cpu_* ports, for the aux requester.
- mem_en  out  1  byte access strobe.
- mem_we  out  1  byte write enable.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte, returned the cycle after mem_en with mem_we=0 (1-cycle latency).
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, BEAT, RTAIL, RESP. A 2-bit beat counter cnt.
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, last_owner=aux.
  - Latched addr/we/wdata=0, rdata register=0.
  - All outputs 0.
  - Reset mid-transaction aborts immediately. Bytes already written stay written; no done pulse is produced.
- IDLE:
  - If any req is high, select owner by the arbitration rule.
  - At the clock edge, latch owner, we, addr and wdata; cnt=0; go to BEAT.
  - Nothing is latched when no req is high.
- Arbitration (default): round-robin.
  - With both requests high, the winner is the requester that is not last_owner.
  - last_owner updates at grant.
  - After reset, cpu wins the first tie.
- BEAT:
  - Drive mem_en=1, mem_we=we, mem_addr=(addr+cnt) mod 2**ADDR_W.
  - mem_wdata = wdata byte cnt (cnt 0 -> [31:24], cnt 3 -> [7:0]).
  - Reads: when cnt>=1, capture mem_rdata into rdata byte cnt-1.
  - cnt increments each cycle. After cnt=3: write -> RESP; read -> RTAIL.
- RTAIL (reads only): mem_en=0; capture mem_rdata into rdata[7:0]; go to RESP.
- RESP:
  - The owner's done=1 for exactly one cycle; rdata is presented on both *_rdata outputs.
  - Go to IDLE.
- Outputs outside the states above:
  - *_gnt is high for the owner in BEAT, RTAIL and RESP.
  - mem_en=0 outside BEAT.
  - rdata holds its last value; a write does not modify it.
- Latency, counted from the edge that accepts the request:
  - write: done is high in the 5th cycle;
  - read: done is high in the 6th cycle.
- Back-to-back: after RESP there is always one IDLE cycle. Maximum throughput is one write per 6 cycles and one read per 7.
- Boundaries:
  - Unaligned addresses are legal.
  - Byte addresses wrap modulo 2**ADDR_W (e.g. addr=30 accesses bytes 30,31,0,1).
  - The losing requester waits with its req held; no request is ever dropped.
  - Req deasserted mid-transaction is ignored; the transaction completes and done still pulses.
  - Req still high in the IDLE cycle after done starts a new transaction.

Optional Feature:
- Macro DMEM_PORT_ARBITER_CPU_PRIO_EN.
  - Defined: fixed priority. cpu always wins when both requests are high in IDLE; last_owner is not used.
  - Undefined: round-robin as described in Behaviour.

Test Plan:
- Writes: cpu write addr=4, wdata=32'hDEADBEEF.
  - Beats drive mem_addr 4,5,6,7 with bytes DE,AD,BE,EF.
  - cpu_done is high in the 5th cycle after acceptance; cpu_stall is high until then.
- Reads: memory bytes 8..11 = 12,34,56,78; cpu read addr=8.
  - cpu_done is high in the 6th cycle with cpu_rdata=32'h12345678.
  - Then an aux write follows; rdata is unchanged.
- Wrap: aux write addr=30, wdata=32'hA1B2C3D4.
  - Bytes 30,31,0,1 become A1,B2,C3,D4.
  - A readback from addr=30 returns 32'hA1B2C3D4.
- Contention: cpu_req and aux_req held high continuously from reset.
  - Grants alternate cpu, aux, cpu, aux.
  - With DMEM_PORT_ARBITER_CPU_PRIO_EN defined, cpu is granted every time.
- Reset mid-op: cpu write of 32'hFFFFFFFF to addr 0 over memory zeros; rst_n=0 asynchronously during beat cnt=2.
  - Outputs go to 0 immediately, with no cpu_done.
  - Bytes 0,1 = FF and bytes 2,3 = 00.
  - After release, a fresh request completes normally.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: cpu/aux request ports and byte-wide memory port of dmem_port_arbiter.
interface dmem_port_arbiter_if #(parameter int ADDR_W = 5);
   logic              cpu_req, cpu_we, cpu_gnt, cpu_done, cpu_stall;
   logic [ADDR_W-1:0] cpu_addr;
   logic [31:0]       cpu_wdata, cpu_rdata;
   logic              aux_req, aux_we, aux_gnt, aux_done;
   logic [ADDR_W-1:0] aux_addr;
   logic [31:0]       aux_wdata, aux_rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata, mem_rdata;
   logic              busy;
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, aux_req, aux_we, aux_addr, aux_wdata, mem_rdata,
      output cpu_gnt, cpu_done, cpu_rdata, cpu_stall, aux_gnt, aux_done, aux_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, aux_req, aux_we, aux_addr, aux_wdata, mem_rdata,
      input  cpu_gnt, cpu_done, cpu_rdata, cpu_stall, aux_gnt, aux_done, aux_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: serialises cpu/aux 32-bit accesses onto a byte-wide memory, big-endian.
// Round-robin arbitration; define DMEM_PORT_ARBITER_CPU_PRIO_EN for fixed cpu priority.
module dmem_port_arbiter #(parameter int ADDR_W = 5) (
   input logic clk,
   input logic rst_n,
   dmem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BEAT, RTAIL, RESP} state_t;
   state_t            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              own_q, own_d, last_q, last_d, we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
   logic              cpu_win, beat, resp;
`ifdef DMEM_PORT_ARBITER_CPU_PRIO_EN
   assign cpu_win = bus.cpu_req;
`else
   assign cpu_win = bus.cpu_req & (~bus.aux_req | last_q);
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         own_q   <= 1'b0;
         last_q  <= 1'b1;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         own_q   <= own_d;
         last_q  <= last_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end
   // Read bytes arrive in order, so shifting each one in lands it in its big-endian slot.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      own_d   = own_q;
      last_d  = last_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: if (bus.cpu_req | bus.aux_req) begin
            own_d   = ~cpu_win;
            last_d  = ~cpu_win;
            we_d    = cpu_win ? bus.cpu_we : bus.aux_we;
            addr_d  = cpu_win ? bus.cpu_addr : bus.aux_addr;
            wdata_d = cpu_win ? bus.cpu_wdata : bus.aux_wdata;
            cnt_d   = '0;
            state_d = BEAT;
         end
         BEAT: begin
            cnt_d = cnt_q + 2'd1;
            if (!we_q && cnt_q != 2'd0) rdata_d = {rdata_q[23:0], bus.mem_rdata};
            if (cnt_q == 2'd3) state_d = we_q ? RESP : RTAIL;
         end
         RTAIL: begin
            rdata_d = {rdata_q[23:0], bus.mem_rdata};
            state_d = RESP;
         end
         RESP: state_d = IDLE;
      endcase
   end
   always_comb begin
      beat          = state_q == BEAT;
      resp          = state_q == RESP;
      bus.busy      = state_q != IDLE;
      bus.mem_en    = beat;
      bus.mem_we    = beat & we_q;
      bus.mem_addr  = beat ? addr_q + ADDR_W'(cnt_q) : '0;
      bus.mem_wdata = beat ? wdata_q[{~cnt_q, 3'b000} +: 8] : 8'h00;
      bus.cpu_gnt   = bus.busy & ~own_q;
      bus.aux_gnt   = bus.busy & own_q;
      bus.cpu_done  = resp & ~own_q;
      bus.aux_done  = resp & own_q;
      bus.cpu_rdata = rdata_q;
      bus.aux_rdata = rdata_q;
      bus.cpu_stall = bus.cpu_req & ~bus.cpu_done;
   end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: scoreboard bench for dmem_port_arbiter with a 1-cycle-latency byte memory.
module tb_dmem_port_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;
   dmem_port_arbiter_if #(.ADDR_W(5)) bus();
   dmem_port_arbiter #(.ADDR_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   logic [7:0]  mem [32];
   logic [7:0]  mrd;
   logic [31:0] sb_q [$];
   logic [1:0]  own_sb [$];
   int n_cmp = 0;
   int n_bad = 0;
   assign bus.mem_rdata = mrd;
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
         else mrd <= mem[bus.mem_addr];
      end
   end
   task automatic idle_inputs();
      bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.aux_req = 0; bus.aux_we = 0; bus.aux_addr = '0; bus.aux_wdata = '0;
   endtask
   task automatic do_reset();
      rst_n = 0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
   endtask
   task automatic drive(input bit aux, input bit we, input logic [4:0] a, input logic [31:0] d);
      if (aux) begin bus.aux_req = 1; bus.aux_we = we; bus.aux_addr = a; bus.aux_wdata = d; end
      else begin bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d; end
   endtask
   task automatic run_op(input bit aux, input bit we, input logic [4:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd);
      drive(aux, we, a, d);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (aux ? bus.aux_done : bus.cpu_done) begin lat = i; break; end
      end
      rd = aux ? bus.aux_rdata : bus.cpu_rdata;
      bus.cpu_req = 0;
      bus.aux_req = 0;
      @(negedge clk);
   endtask
   task automatic test_reset();
      rst_n = 0;
      idle_inputs();
      @(negedge clk);
      n_cmp++;
      if ({bus.cpu_gnt, bus.aux_gnt, bus.cpu_done, bus.aux_done, bus.mem_en, bus.mem_we, bus.busy, bus.cpu_stall} !== 8'h00) begin
         n_bad++; $display("FAIL reset_ctrl: got %b expected 00000000",
            {bus.cpu_gnt, bus.aux_gnt, bus.cpu_done, bus.aux_done, bus.mem_en, bus.mem_we, bus.busy, bus.cpu_stall});
      end
      n_cmp++;
      if ({bus.mem_addr, bus.mem_wdata} !== 13'h0) begin
         n_bad++; $display("FAIL reset_mem: got %h expected 0", {bus.mem_addr, bus.mem_wdata});
      end
      n_cmp++;
      if ({bus.cpu_rdata, bus.aux_rdata} !== 64'h0) begin
         n_bad++; $display("FAIL reset_rdata: got %h expected 0", {bus.cpu_rdata, bus.aux_rdata});
      end
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_no_req: busy=%b expected 0", bus.busy); end
      end
   endtask
   task automatic test_write();
      logic [7:0] eb [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      int done_at = -1;
      drive(0, 1, 5'd4, 32'hDEADBEEF);
      for (int i = 1; i <= 8 && done_at < 0; i++) begin
         @(negedge clk);
         if (bus.cpu_done) done_at = i;
         else begin
            n_cmp++;
            if (bus.cpu_stall !== 1'b1) begin n_bad++; $display("FAIL wr_stall: cycle %0d got %b expected 1", i, bus.cpu_stall); end
         end
         if (i <= 4) begin
            n_cmp++;
            if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_gnt} !== {1'b1, 1'b1, 5'(3 + i), eb[i-1], 1'b1}) begin
               n_bad++; $display("FAIL wr_beat%0d: got en=%b we=%b addr=%0d data=%h gnt=%b expected 1 1 %0d %h 1",
                  i - 1, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_gnt, 3 + i, eb[i-1]);
            end
         end
      end
      n_cmp++;
      if (done_at != 5) begin n_bad++; $display("FAIL wr_latency: got %0d expected 5", done_at); end
      n_cmp++;
      if (bus.cpu_stall !== 1'b0) begin n_bad++; $display("FAIL wr_stall_done: got %b expected 0", bus.cpu_stall); end
      bus.cpu_req = 0;
      @(negedge clk);
      n_cmp++;
      if ({mem[4], mem[5], mem[6], mem[7]} !== 32'hDEADBEEF) begin
         n_bad++; $display("FAIL wr_mem: got %h expected deadbeef", {mem[4], mem[5], mem[6], mem[7]});
      end
   endtask
   task automatic test_read();
      int lat;
      logic [31:0] rd, exp;
      mem[8] = 8'h12; mem[9] = 8'h34; mem[10] = 8'h56; mem[11] = 8'h78;
      sb_q.push_back(32'h12345678);
      run_op(0, 0, 5'd8, 32'h0, lat, rd);
      exp = sb_q.pop_front();
      n_cmp++;
      if (rd !== exp) begin n_bad++; $display("FAIL rd_data: got %h expected %h", rd, exp); end
      n_cmp++;
      if (lat != 6) begin n_bad++; $display("FAIL rd_latency: got %0d expected 6", lat); end
      run_op(1, 1, 5'd16, 32'h0BADF00D, lat, rd);
      n_cmp++;
      if (lat != 5) begin n_bad++; $display("FAIL aux_wr_latency: got %0d expected 5", lat); end
      n_cmp++;
      if ({bus.cpu_rdata, bus.aux_rdata} !== {exp, exp}) begin
         n_bad++; $display("FAIL rd_hold: got %h expected %h%h", {bus.cpu_rdata, bus.aux_rdata}, exp, exp);
      end
   endtask
   task automatic test_wrap();
      int lat;
      logic [31:0] rd, exp;
      mem[2] = 8'h5A;
      run_op(1, 1, 5'd30, 32'hA1B2C3D4, lat, rd);
      n_cmp++;
      if ({mem[30], mem[31], mem[0], mem[1], mem[2]} !== 40'hA1B2C3D45A) begin
         n_bad++; $display("FAIL wrap_mem: got %h expected a1b2c3d45a", {mem[30], mem[31], mem[0], mem[1], mem[2]});
      end
      sb_q.push_back(32'hA1B2C3D4);
      run_op(1, 0, 5'd30, 32'h0, lat, rd);
      exp = sb_q.pop_front();
      n_cmp++;
      if (rd !== exp || lat != 6) begin n_bad++; $display("FAIL wrap_read: got %h lat %0d expected %h lat 6", rd, lat, exp); end
   endtask
   task automatic test_contention();
      int seen = 0;
      int last_t = -1;
      logic [1:0] e;
      do_reset();
      for (int i = 0; i < 4; i++) begin
`ifdef DMEM_PORT_ARBITER_CPU_PRIO_EN
         own_sb.push_back(2'b10);
`else
         own_sb.push_back(i % 2 == 0 ? 2'b10 : 2'b01);
`endif
      end
      drive(0, 1, 5'd12, 32'h11111111);
      drive(1, 1, 5'd20, 32'h22222222);
      for (int t = 1; t <= 60 && seen < 4; t++) begin
         @(negedge clk);
         if (bus.cpu_done | bus.aux_done) begin
            e = own_sb.pop_front();
            n_cmp++;
            if ({bus.cpu_done, bus.aux_done} !== e) begin
               n_bad++; $display("FAIL arb_grant%0d: got cpu/aux done %b expected %b", seen, {bus.cpu_done, bus.aux_done}, e);
            end
            if (last_t >= 0) begin
               n_cmp++;
               if (t - last_t != 6) begin n_bad++; $display("FAIL arb_spacing%0d: got %0d expected 6", seen, t - last_t); end
            end
            last_t = t;
            seen++;
         end
      end
      n_cmp++;
      if (seen != 4) begin n_bad++; $display("FAIL arb_timeout: got %0d dones expected 4", seen); end
      own_sb.delete();
      idle_inputs();
      repeat (8) @(negedge clk);
   endtask
   task automatic test_reset_midop();
      int lat;
      logic [31:0] rd, exp;
      do_reset();
      mem[0] = 0; mem[1] = 0; mem[2] = 0; mem[3] = 0;
      drive(0, 1, 5'd0, 32'hFFFFFFFF);
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({bus.mem_en, bus.mem_addr} !== {1'b1, 5'd2}) begin
         n_bad++; $display("FAIL midop_beat2: got en=%b addr=%0d expected 1 2", bus.mem_en, bus.mem_addr);
      end
      #1 rst_n = 0;
      #1;
      n_cmp++;
      if ({bus.cpu_gnt, bus.cpu_done, bus.mem_en, bus.mem_we, bus.busy, bus.mem_addr, bus.mem_wdata} !== 18'h0) begin
         n_bad++; $display("FAIL midop_async: got %h expected 0",
            {bus.cpu_gnt, bus.cpu_done, bus.mem_en, bus.mem_we, bus.busy, bus.mem_addr, bus.mem_wdata});
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.cpu_done !== 1'b0) begin n_bad++; $display("FAIL midop_no_done: got %b expected 0", bus.cpu_done); end
      end
      bus.cpu_req = 0;
      n_cmp++;
      if ({mem[0], mem[1], mem[2], mem[3]} !== 32'hFFFF0000) begin
         n_bad++; $display("FAIL midop_mem: got %h expected ffff0000", {mem[0], mem[1], mem[2], mem[3]});
      end
      rst_n = 1;
      @(negedge clk);
      sb_q.push_back(32'hFFFF0000);
      run_op(0, 0, 5'd0, 32'h0, lat, rd);
      exp = sb_q.pop_front();
      n_cmp++;
      if (rd !== exp || lat != 6) begin n_bad++; $display("FAIL midop_recover: got %h lat %0d expected %h lat 6", rd, lat, exp); end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
      test_reset();
      test_write();
      test_read();
      test_wrap();
      test_contention();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
